// File: rtl/serial_unsigned_subtractor_borrow_pkg.sv
// rtl/serial_unsigned_subtractor_borrow_pkg.sv - shared state encoding and sizing helpers for the serial subtractor
package serial_unsigned_subtractor_borrow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic int digit_count(input int width, input int digit);
    return (digit < 1) ? 1 : width / digit;
  endfunction

  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = digit_count(width, digit);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// rtl/serial_sub_digit.sv - combinational DIGIT-bit subtract with borrow in/out
module serial_sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             bin_i,
  output logic [DIGIT-1:0] diff_o,
  output logic             bout_o
);

  // One extra bit: a negative result wraps and leaves the borrow in the MSB.
  logic [DIGIT:0] res;

  assign res              = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT{1'b0}}, bin_i};
  assign {bout_o, diff_o} = res;

endmodule

// File: rtl/serial_unsigned_subtractor_borrow.sv
// rtl/serial_unsigned_subtractor_borrow.sv - digit-serial A - B with borrow out; optional BI port under BORROW_IN_EN
module serial_unsigned_subtractor_borrow
  import serial_unsigned_subtractor_borrow_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef BORROW_IN_EN
  input  logic             BI,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BO
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_unsigned_subtractor_borrow: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, part_d, diff_q;
  logic             borrow_q, bo_q, busy_q, done_q;
  logic             bi_w;
  logic [31:0]      sh;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIGIT-1:0] d_dig;
  logic             d_bout;

`ifdef BORROW_IN_EN
  assign bi_w = BI;
`else
  assign bi_w = 1'b0;
`endif

  // Digit k lives at bit offset k*DIGIT of the operands and the partial result.
  assign sh   = 32'(cnt_q) * 32'(DIGIT);
  assign a_sh = a_q >> sh;
  assign b_sh = b_q >> sh;

  serial_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i    (a_sh[DIGIT-1:0]),
    .b_i    (b_sh[DIGIT-1:0]),
    .bin_i  (borrow_q),
    .diff_o (d_dig),
    .bout_o (d_bout)
  );

  always_comb begin
    part_d = (part_q & ~(DMASK << sh)) | (WIDTH'(d_dig) << sh);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bo_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          part_q   <= part_d;
          borrow_q <= d_bout;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            diff_q  <= part_d;
            bo_q    <= d_bout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        // IDLE and FIN both accept, so back-to-back operations need no idle cycle.
        default: begin
          if (START) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= bi_w;
            cnt_q    <= '0;
            part_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign DIFF = diff_q;
  assign BO   = bo_q;

endmodule

// File: tb/tb_serial_unsigned_subtractor_borrow.sv
// tb/tb_serial_unsigned_subtractor_borrow.sv - scoreboard bench for DIGIT=1 and DIGIT=4 instances
module tb_serial_unsigned_subtractor_borrow;

  typedef struct {
    logic [7:0] d;
    logic       b;
  } exp_t;

  logic       clk, rst;
  logic       start8, start4;
  logic [7:0] a8, b8, a4, b4;
  logic       busy8, done8, bo8, busy4, done4, bo4;
  logic [7:0] diff8, diff4;
`ifdef BORROW_IN_EN
  logic       bi4;
`endif

  exp_t q8[$];
  exp_t q4[$];
  exp_t e8, e4;
  int   checks = 0;
  int   errors = 0;
  int   dcnt8 = 0, dcnt4 = 0, nexp8 = 0, nexp4 = 0;

  serial_unsigned_subtractor_borrow #(.WIDTH(8), .DIGIT(1)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8),
`ifdef BORROW_IN_EN
    .BI(1'b0),
`endif
    .BUSY(busy8), .DONE(done8), .DIFF(diff8), .BO(bo8)
  );

  serial_unsigned_subtractor_borrow #(.WIDTH(8), .DIGIT(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .A(a4), .B(b4),
`ifdef BORROW_IN_EN
    .BI(bi4),
`endif
    .BUSY(busy4), .DONE(done4), .DIFF(diff4), .BO(bo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done8) begin
      dcnt8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got DONE with diff=%0h, expected no DONE", diff8);
      end else begin
        e8 = q8.pop_front();
        chk("diff8", diff8, e8.d);
        chk("bo8", bo8, e8.b);
        chk("busy8_at_done", busy8, 0);
      end
    end
    if (!rst && done4) begin
      dcnt4++;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done4: got DONE with diff=%0h, expected no DONE", diff4);
      end else begin
        e4 = q4.pop_front();
        chk("diff4", diff4, e4.d);
        chk("bo4", bo4, e4.b);
        chk("busy4_at_done", busy4, 0);
      end
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed, input logic eb);
    q8.push_back('{d: ed, b: eb});
    nexp8++;
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk) #1;
    start8 = 1'b0;
    chk("busy8_after_start", busy8, 1);
  endtask

  task automatic run4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed, input logic eb);
    q4.push_back('{d: ed, b: eb});
    nexp4++;
    a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk) #1;
    start4 = 1'b0;
    chk("busy4_after_start", busy4, 1);
  endtask

  // Counts edges until DONE; mid-way the previous result must still be on DIFF.
  task automatic wait_done(input bit sel, input int lat, input logic [7:0] prev);
    int   cyc;
    logic dn;
    cyc = 0;
    dn  = sel ? done4 : done8;
    while (!dn && cyc < 40) begin
      @(posedge clk) #1;
      cyc++;
      if (cyc == lat / 2) begin
        chk("diff_held_mid_run", sel ? diff4 : diff8, prev);
        chk("busy_mid_run", sel ? busy4 : busy8, 1);
      end
      dn = sel ? done4 : done8;
    end
    chk("done_latency", cyc, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
`ifdef BORROW_IN_EN
    bi4 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy8", busy8, 0);
    chk("reset_done8", done8, 0);
    chk("reset_diff8", diff8, 0);
    chk("reset_bo8", bo8, 0);
    chk("reset_busy4", busy4, 0);
    chk("reset_diff4", diff4, 0);

    run8(8'h50, 8'h20, 8'h30, 1'b0); wait_done(0, 8, 8'h00);
    @(posedge clk) #1; chk("done8_one_cycle", done8, 0);
    run8(8'h20, 8'h50, 8'hD0, 1'b1); wait_done(0, 8, 8'h30);
    @(posedge clk) #1;
    run8(8'h00, 8'h01, 8'hFF, 1'b1); wait_done(0, 8, 8'hD0);
    @(posedge clk) #1;
    run8(8'hA5, 8'hA5, 8'h00, 1'b0); wait_done(0, 8, 8'hFF);
    @(posedge clk) #1;
    run8(8'h00, 8'hFF, 8'h01, 1'b1); wait_done(0, 8, 8'h00);
    @(posedge clk) #1;

    run8(8'h81, 8'h7E, 8'h03, 1'b0);
    repeat (2) @(posedge clk) #1;
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk) #1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    wait_done(0, 5, 8'h01);

    a8 = 8'h03; b8 = 8'h04; start8 = 1'b1;
    q8.push_back('{d: 8'hFF, b: 1'b1});
    nexp8++;
    @(posedge clk) #1;
    start8 = 1'b0;
    chk("b2b_busy8", busy8, 1);
    chk("b2b_diff8_held", diff8, 8'h03);
    wait_done(0, 8, 8'h03);
    @(posedge clk) #1;

    a8 = 8'h50; b8 = 8'h20; start8 = 1'b1;
    @(posedge clk) #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_diff8", diff8, 0);
    chk("abort_bo8", bo8, 0);
    repeat (12) @(posedge clk) #1;
    run8(8'h50, 8'h20, 8'h30, 1'b0); wait_done(0, 8, 8'h00);
    @(posedge clk) #1;

    run4(8'h10, 8'h01, 8'h0F, 1'b0); wait_done(1, 2, 8'h00);
    @(posedge clk) #1;
    run4(8'h00, 8'hFF, 8'h01, 1'b1); wait_done(1, 2, 8'h0F);
    @(posedge clk) #1;
`ifdef BORROW_IN_EN
    bi4 = 1'b1;
    run4(8'h10, 8'h10, 8'hFF, 1'b1); wait_done(1, 2, 8'h01);
    @(posedge clk) #1;
    run4(8'h10, 8'h0F, 8'h00, 1'b0); wait_done(1, 2, 8'hFF);
    bi4 = 1'b0;
    @(posedge clk) #1;
`endif

    repeat (4) @(posedge clk) #1;
    chk("done8_count", dcnt8, nexp8);
    chk("done4_count", dcnt4, nexp4);
    chk("queue8_drained", q8.size(), 0);
    chk("queue4_drained", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_unsigned_subtractor_borrow.md
Name: serial_unsigned_subtractor_borrow

Overview:
Multi-cycle unsigned subtractor with borrow-out. It computes DIFF = A - B mod 2^WIDTH, with BO = 1 when A < B, processing DIGIT bits per clock, LSB first. This is the subtract counterpart of the datapath's unsigned adder with carry-out. It is intended for area-constrained datapaths where a full-width combinational subtract is not wanted.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
DIGIT, 1, bits processed per clock; must divide WIDTH exactly; N = WIDTH/DIGIT is the digit count.

Ports:
CLK  input  1  single system clock; all state changes on the rising edge.
RST  input  1  synchronous, active-high reset.
START  input  1  request; sampled only when BUSY = 0.
A  input  WIDTH  minuend; sampled on the accepting edge only.
B  input  WIDTH  subtrahend; sampled on the accepting edge only.
BUSY  output  1  high while the subtraction is in progress.
DONE  output  1  one-cycle pulse; DIFF/BO are valid and newly updated.
DIFF  output  WIDTH  result A - B mod 2^WIDTH; held until the next completion.
BO  output  1  borrow out; 1 iff A < B (unsigned); held with DIFF.

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values:
  - BUSY = 0, DONE = 0, DIFF = 0, BO = 0.
  - State = IDLE; internal operand and partial-result registers and the digit counter are cleared.
- States:
  - IDLE: BUSY = 0, DONE = 0.
  - RUN: BUSY = 1.
  - FIN: BUSY = 0, DONE = 1 for exactly one cycle.
- Accept:
  - At a rising edge where BUSY = 0 and START = 1, latch A, B, borrow = 0 and counter = 0, then go to RUN.
  - START is also accepted in FIN, which allows back-to-back operations.
- RUN, each edge:
  - Subtract digit k of A and B with the running borrow.
  - Write the DIGIT result bits into partial-result slice k.
  - Update the borrow and increment the counter.
  - At the edge processing digit N-1: commit the partial result to DIFF, commit the final borrow to BO, go to FIN.
- Latency:
  - START is sampled at edge t0; DONE is high during the cycle following edge tN, where N = WIDTH/DIGIT.
  - BUSY is high from t0 to tN. For WIDTH = 8, DIGIT = 1, DONE follows 8 edges after START.
- FIN: with START = 0, return to IDLE at the next edge; with START = 1, go to RUN with new operands.
- START while BUSY = 1: ignored. There is no queueing, and the in-flight operation is unaffected.
- Output stability:
  - DIFF and BO change only at the commit edge, never during RUN.
  - Previous results remain readable while a new operation runs.
- Arithmetic:
  - Per digit: the digit of A minus the digit of B minus the borrow-in, computed at DIGIT+1 bits.
  - The MSB of that DIGIT+1-bit result is the borrow-out.
  - No signed interpretation.
- Boundaries:
  - A = B gives DIFF = 0, BO = 0.
  - A = 0, B = 2^WIDTH-1 gives DIFF = 1, BO = 1.
  - Wrap-around is modulo 2^WIDTH.
- RST asserted mid-RUN: the operation is aborted and all outputs return to reset values at that edge. There is no DONE pulse.
- RST and START high at the same edge: RST wins and START is ignored.

Optional Feature:
Macro: BORROW_IN_EN.
- Defined:
  - Adds port BI, input, 1 bit, sampled together with A and B on the accepting edge.
  - BI is used as the initial borrow, so DIFF = A - B - BI mod 2^WIDTH and BO = 1 iff A < B + BI.
  - This allows chaining wider subtracts.
- Undefined: port BI is absent and the initial borrow is the constant 0.

Decomposition:
- Shared package:
  - State encoding constants IDLE, RUN, FIN (2-bit).
  - Constant-function digit count N = WIDTH/DIGIT and counter width = clog2(N), minimum 1.
  - Parameter legality check (DIGIT divides WIDTH), reported at elaboration.
- One sub-module, serial_sub_digit: purely combinational DIGIT-bit subtract.
  - Inputs: a digit, b digit, borrow-in.
  - Outputs: difference digit, borrow-out.
  - Instantiated once; the top module holds the FSM, counter and shift/slice registers.

Test Plan:
1. WIDTH = 8, DIGIT = 1, A = 0x50, B = 0x20, START for 1 cycle -> BUSY high for 8 edges, then DONE one cycle with DIFF = 0x30, BO = 0.
2. A = 0x20, B = 0x50 -> DIFF = 0xD0, BO = 1. A = 0x00, B = 0x01 -> DIFF = 0xFF, BO = 1. A = 0xA5, B = 0xA5 -> DIFF = 0x00, BO = 0.
3. START pulsed again mid-RUN with A = 0xFF, B = 0x00 -> ignored; the first operation completes with its original result and only one DONE pulse occurs.
4. START held high through FIN with new operands A = 0x03, B = 0x04 -> second operation begins immediately; DONE pulses again 8 edges later with DIFF = 0xFF, BO = 1. The prior DIFF is held until then.
5. RST asserted at the 4th RUN edge -> BUSY, DONE, DIFF and BO = 0 at that edge, no DONE pulse. A fresh START then completes normally.
6. WIDTH = 8, DIGIT = 4, A = 0x10, B = 0x01 -> DONE after 2 edges, DIFF = 0x0F, BO = 0. With BORROW_IN_EN defined: A = 0x10, B = 0x10, BI = 1 -> DIFF = 0xFF, BO = 1.
